// File: rtl/video_linebuffer_pkg.sv
// Shared video constants and the line-request decode used by the scanline buffer.
package video_linebuffer_pkg;

    localparam int unsigned LINE_PAIRS_LAST = 262;
    localparam int unsigned VSYNC_PAIR      = 245;
    localparam int unsigned VIS_LINES       = 240;
    localparam int unsigned LINEBUF_DEPTH   = 512;

    // Pair-counter constants in the counter's own width
    localparam logic [8:0] PAIR_LAST    = 9'(LINE_PAIRS_LAST);
    localparam logic [8:0] PAIR_RESYNC  = 9'(VSYNC_PAIR + 1);
    localparam logic [8:0] PAIR_REQ_END = 9'(VIS_LINES - 1);

    typedef struct packed {
        logic       req;
        logic [7:0] line;
    } render_req_t;

    // Which line (if any) to request when the display enters pair 'pair'.
    // Visible pairs fetch one line ahead; the single-raster pair 262
    // fetches line 0 for the top of the next frame.
    function automatic render_req_t render_req_for(input logic [8:0] pair);
        render_req_t r;
        r.req  = 1'b0;
        r.line = 8'd0;
        if (pair < PAIR_REQ_END) begin
            r.req  = 1'b1;
            r.line = 8'(pair + 9'd1);
        end else if (pair == PAIR_LAST) begin
            r.req  = 1'b1;
            r.line = 8'd0;
        end else begin
            r.req  = 1'b0;
            r.line = 8'd0;
        end
        return r;
    endfunction

endpackage

// File: rtl/video_linebuffer_linebuf_ram.sv
// Simple dual-port line RAM: synchronous write, registered read.
module linebuf_ram #(
    parameter int PIX_W = 8,
    parameter int AW    = 10,
    parameter int DEPTH = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [PIX_W-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [PIX_W-1:0] rd_data
);

    logic [PIX_W-1:0] mem_r [DEPTH];
    logic [PIX_W-1:0] rd_data_r;

    // Write port; storage itself is not reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered read port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_r <= {PIX_W{1'b0}};
        end else begin
            rd_data_r <= mem_r[rd_addr];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/video_linebuffer.sv
// Double-buffered scanline buffer: displays one bank (each line doubled
// horizontally and vertically) while the renderer fills the other bank.
module video_linebuffer
    import video_linebuffer_pkg::*;
#(
    parameter int               PIX_W  = 8,
    parameter logic [PIX_W-1:0] BORDER = {PIX_W{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [9:0]       hpos,
    input  logic             hsync,
    input  logic             vsync,
    input  logic             blank,
    input  logic             hlast,
    input  logic             vnext,
    output logic             render_start,
    output logic [7:0]       render_line,
    input  logic             render_done,
    input  logic             wr_en,
    input  logic [8:0]       wr_addr,
    input  logic [PIX_W-1:0] wr_data,
    output logic [PIX_W-1:0] pix_data,
    output logic             pix_hsync,
    output logic             pix_vsync,
    output logic             pix_blank,
    output logic             overrun
);

    logic [8:0]       pair_cnt_r;
    logic             disp_bank_r;
    logic             busy_r;
    logic             render_start_r;
    logic [7:0]       render_line_r;
    logic             overrun_r;

    logic             pair_wrap_s;
    logic             swap_s;
    logic [8:0]       pair_next_s;
    render_req_t      req_s;
    logic             busy_next_s;

    logic [9:0]       rd_addr_s;
    logic [9:0]       wr_addr_s;
    logic [PIX_W-1:0] rd_data_s;
    logic             unused_hpos_lsb_s;

    logic             hsync_d1_r;
    logic             vsync_d1_r;
    logic             blank_d1_r;
    logic [PIX_W-1:0] pix_data_r;
    logic             pix_hsync_r;
    logic             pix_vsync_r;
    logic             pix_blank_r;

    // Swap detection, next line pair and the request it implies
    always_comb begin
        pair_wrap_s = hlast & (pair_cnt_r == PAIR_LAST);
        swap_s      = vnext | pair_wrap_s;
        pair_next_s = pair_cnt_r;
        if (vnext) begin
            // vsync low on a pair boundary re-anchors the count after a bad reset
            if (!vsync) begin
                pair_next_s = PAIR_RESYNC;
            end else begin
                pair_next_s = pair_cnt_r + 9'd1;
            end
        end else if (pair_wrap_s) begin
            pair_next_s = 9'd0;
        end else begin
            pair_next_s = pair_cnt_r;
        end
        req_s = render_req_for(pair_next_s);
    end

    // Busy tracking: a done pulse in the request cycle belongs to the old line
    always_comb begin
        busy_next_s = busy_r;
        if (swap_s && req_s.req) begin
            busy_next_s = 1'b1;
        end else if (render_start_r) begin
            busy_next_s = busy_r;
        end else if (render_done) begin
            busy_next_s = 1'b0;
        end else begin
            busy_next_s = busy_r;
        end
    end

    // Pair counter, bank select, render request and overrun registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair_cnt_r     <= 9'd0;
            disp_bank_r    <= 1'b0;
            busy_r         <= 1'b0;
            render_start_r <= 1'b0;
            render_line_r  <= 8'd0;
            overrun_r      <= 1'b0;
        end else begin
            pair_cnt_r     <= pair_next_s;
            busy_r         <= busy_next_s;
            render_start_r <= swap_s & req_s.req;
            overrun_r      <= swap_s & busy_r;
            if (swap_s) begin
                disp_bank_r <= ~disp_bank_r;
            end
            if (swap_s && req_s.req) begin
                render_line_r <= req_s.line;
            end
        end
    end

    // Display reads the shown bank at half horizontal rate; writes go to the other
    assign rd_addr_s         = {disp_bank_r, hpos[9:1]};
    assign wr_addr_s         = {~disp_bank_r, wr_addr};
    assign unused_hpos_lsb_s = hpos[0];

    linebuf_ram #(
        .PIX_W (PIX_W),
        .AW    (10),
        .DEPTH (2 * LINEBUF_DEPTH)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr_s),
        .wr_data (wr_data),
        .rd_addr (rd_addr_s),
        .rd_data (rd_data_s)
    );

    // Sync/blank stage 1, alongside the RAM read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_d1_r <= 1'b1;
            vsync_d1_r <= 1'b1;
            blank_d1_r <= 1'b1;
        end else begin
            hsync_d1_r <= hsync;
            vsync_d1_r <= vsync;
            blank_d1_r <= blank;
        end
    end

    // Output stage: border substitution while blanked
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_data_r  <= BORDER;
            pix_hsync_r <= 1'b1;
            pix_vsync_r <= 1'b1;
            pix_blank_r <= 1'b1;
        end else begin
            pix_data_r  <= blank_d1_r ? BORDER : rd_data_s;
            pix_hsync_r <= hsync_d1_r;
            pix_vsync_r <= vsync_d1_r;
            pix_blank_r <= blank_d1_r;
        end
    end

    assign pix_data     = pix_data_r;
    assign pix_hsync    = pix_hsync_r;
    assign pix_vsync    = pix_vsync_r;
    assign pix_blank    = pix_blank_r;
    assign render_start = render_start_r;
    assign render_line  = render_line_r;
    assign overrun      = overrun_r;

endmodule

// File: tb/tb_video_linebuffer.sv
// Scoreboard bench for video_linebuffer: a shortened-raster timing generator
// and a simple renderer drive the DUT; expectations are queued as stimulus is
// issued and a negedge monitor pops and compares them.
module tb_video_linebuffer;

    localparam int         PIX_W     = 8;
    localparam logic [7:0] BORDER    = 8'hE7;
    localparam int         H_TOT     = 24;
    localparam int         H_VIS     = 16;
    localparam int         HS_BEG    = 18;
    localparam int         HS_END    = 21;
    localparam int         RASTERS   = 525;
    localparam int         V_VIS     = 480;
    localparam int         N_PIX     = 12;
    localparam int         HOLD_LINE = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [9:0]       hpos = 10'd0;
    logic             hsync = 1'b1;
    logic             vsync = 1'b1;
    logic             blank = 1'b1;
    logic             hlast = 1'b0;
    logic             vnext = 1'b0;
    logic             render_start;
    logic [7:0]       render_line;
    logic             render_done = 1'b0;
    logic             wr_en = 1'b0;
    logic [8:0]       wr_addr = 9'd0;
    logic [PIX_W-1:0] wr_data = 8'd0;
    logic [PIX_W-1:0] pix_data;
    logic             pix_hsync;
    logic             pix_vsync;
    logic             pix_blank;
    logic             overrun;

    video_linebuffer #(.PIX_W(PIX_W), .BORDER(BORDER)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .hpos         (hpos),
        .hsync        (hsync),
        .vsync        (vsync),
        .blank        (blank),
        .hlast        (hlast),
        .vnext        (vnext),
        .render_start (render_start),
        .render_line  (render_line),
        .render_done  (render_done),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .pix_data     (pix_data),
        .pix_hsync    (pix_hsync),
        .pix_vsync    (pix_vsync),
        .pix_blank    (pix_blank),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         stamp;
        logic       hs;
        logic       vs;
        logic       bl;
        logic [7:0] pix;
        bit         chk;
    } pix_exp_t;

    typedef struct {
        int         stamp;
        logic [7:0] line;
    } req_exp_t;

    pix_exp_t pix_q[$];
    req_exp_t req_q[$];
    int       ovr_q[$];

    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;
    bit mon_en   = 1'b0;

    // generator state
    int raster = 0, hcnt = 0, frame = 0, rst_cnt = 0;
    int cur_raster = 0, cur_frame = 0;
    int req_cnt[4], ovr_cnt[4], line0_cnt[4];

    // renderer state
    bit         r_active = 1'b0;
    bit         r_hold = 1'b0;
    int         r_addr = 0;
    logic [7:0] r_line = 8'd0;

    // model of the two banks and the control state
    logic [7:0] m_mem [2][512];
    bit         m_known [2][512];
    bit         m_bank = 1'b0, m_busy = 1'b0, m_rs = 1'b0;
    logic [8:0] m_pair = 9'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    function automatic logic [7:0] pixval(input logic [7:0] line, input int addr);
        return 8'(addr) + line - 8'd1;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_pix_data"},     32'(pix_data),     32'(BORDER));
        chk({tag, "_pix_hsync"},    32'(pix_hsync),    32'd1);
        chk({tag, "_pix_vsync"},    32'(pix_vsync),    32'd1);
        chk({tag, "_pix_blank"},    32'(pix_blank),    32'd1);
        chk({tag, "_render_start"}, 32'(render_start), 32'd0);
        chk({tag, "_render_line"},  32'(render_line),  32'd0);
        chk({tag, "_overrun"},      32'(overrun),      32'd0);
    endtask

    // One pixel clock of stimulus plus the matching expectations
    task automatic step();
        pix_exp_t   e;
        req_exp_t   rq;
        bit         swap, req, nb;
        logic [8:0] p;
        logic [7:0] line;
        @(posedge clk);
        #1;
        cyc++;
        rst_n = (rst_cnt == 0);
        if (rst_cnt > 0) rst_cnt--;

        // renderer: answers render_start with N_PIX writes then render_done
        wr_en = 1'b0; wr_addr = 9'd0; wr_data = 8'd0; render_done = 1'b0;
        if (!rst_n) begin
            r_active = 1'b0;
        end else begin
            if (render_start === 1'b1) begin
                r_active = 1'b1;
                r_line   = render_line;
                r_addr   = 0;
                r_hold   = (frame == 0) && (render_line == 8'(HOLD_LINE));
            end
            if (r_active) begin
                if (r_addr < N_PIX) begin
                    wr_en   = 1'b1;
                    wr_addr = 9'(r_addr);
                    wr_data = pixval(r_line, r_addr);
                    r_addr++;
                end else begin
                    r_active    = 1'b0;
                    render_done = !r_hold;
                end
            end else if (frame == 1 && raster == 21 && hcnt == H_TOT - 1) begin
                // write coincident with vnext: lands in the bank about to be shown
                wr_en   = 1'b1;
                wr_addr = 9'd3;
                wr_data = 8'hA5;
            end
        end

        // timing generator
        hpos  = 10'(hcnt);
        hsync = !(hcnt >= HS_BEG && hcnt < HS_END);
        vsync = !((raster / 2) == 245);
        blank = (hcnt >= H_VIS) || (raster >= V_VIS);
        hlast = (hcnt == H_TOT - 1);
        vnext = (hcnt == H_TOT - 1) && (raster % 2 == 1);
        cur_raster = raster;
        cur_frame  = frame;

        if (!rst_n) begin
            pix_q.delete(); req_q.delete(); ovr_q.delete();
            mon_en = 1'b0;
            m_bank = 1'b0; m_busy = 1'b0; m_rs = 1'b0; m_pair = 9'd0;
        end else begin
            mon_en = 1'b1;
            e.stamp = cyc; e.hs = hsync; e.vs = vsync; e.bl = blank;
            if (blank) begin
                e.pix = BORDER; e.chk = 1'b1;
            end else begin
                e.pix = m_mem[m_bank][hcnt / 2];
                e.chk = m_known[m_bank][hcnt / 2];
            end
            pix_q.push_back(e);
            if (wr_en) begin
                m_mem[!m_bank][wr_addr]   = wr_data;
                m_known[!m_bank][wr_addr] = 1'b1;
            end
            swap = vnext || (hlast && m_pair == 9'd262);
            if (vnext) p = vsync ? m_pair + 9'd1 : 9'd246;
            else       p = 9'd0;
            req = 1'b0; line = 8'd0;
            if (p < 9'd239) begin
                req = 1'b1; line = 8'(p + 9'd1);
            end else if (p == 9'd262) begin
                req = 1'b1; line = 8'd0;
            end
            if (swap && m_busy) ovr_q.push_back(cyc + 1);
            if (swap && req) begin
                rq.stamp = cyc + 1; rq.line = line;
                req_q.push_back(rq);
            end
            if (swap && req)       nb = 1'b1;
            else if (m_rs)         nb = m_busy;
            else if (render_done)  nb = 1'b0;
            else                   nb = m_busy;
            m_busy = nb;
            m_rs   = swap && req;
            if (swap) begin
                m_bank = !m_bank;
                m_pair = p;
            end
        end

        hcnt++;
        if (hcnt == H_TOT) begin
            hcnt = 0;
            raster++;
            if (raster == RASTERS) begin
                raster = 0;
                frame++;
            end
        end
    endtask

    // Monitor: pops expectations as the DUT presents each output cycle
    always @(negedge clk) begin : monitor
        pix_exp_t e;
        req_exp_t r;
        bit       exp_rs, exp_ovr;
        int       exp_line;
        if (mon_en) begin
            if (pix_q.size() > 0 && pix_q[0].stamp + 2 == cyc) begin
                e = pix_q.pop_front();
                chk("pix_hsync", 32'(pix_hsync), 32'(e.hs));
                chk("pix_vsync", 32'(pix_vsync), 32'(e.vs));
                chk("pix_blank", 32'(pix_blank), 32'(e.bl));
                if (e.chk) chk("pix_data", 32'(pix_data), 32'(e.pix));
            end

            exp_rs = (req_q.size() > 0) && (req_q[0].stamp == cyc);
            chk("render_start", 32'(render_start), 32'(exp_rs));
            if (exp_rs) begin
                r = req_q.pop_front();
                chk("render_line", 32'(render_line), 32'(r.line));
            end
            if (render_start === 1'b1) begin
                req_cnt[cur_frame]++;
                if (render_line == 8'd0) begin
                    line0_cnt[cur_frame]++;
                    chk("req0_at_pair262", 32'(cur_raster / 2), 32'd262);
                end
                if (cur_frame == 1) begin
                    exp_line = (cur_raster / 2 == 262) ? 0 : cur_raster / 2 + 1;
                    chk("render_line_vs_pair", 32'(render_line), 32'(exp_line));
                end
            end

            exp_ovr = (ovr_q.size() > 0) && (ovr_q[0] == cyc);
            chk("overrun", 32'(overrun), 32'(exp_ovr));
            if (exp_ovr) void'(ovr_q.pop_front());
            if (overrun === 1'b1) ovr_cnt[cur_frame]++;
        end
    end

    initial begin
        // reset with non-idle inputs: outputs must hold their reset values
        hsync = 1'b0; vsync = 1'b0; blank = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check_reset_outputs("reset");

        while (!(frame == 3 && raster == 40)) begin
            if (frame == 2 && raster == 200 && hcnt == 5) rst_cnt = 3;
            step();
            if (rst_n == 1'b0 && rst_cnt == 1) check_reset_outputs("midreset");
        end
        repeat (3) step();

        chk("requests_frame1", 32'(req_cnt[1]),   32'd240);
        chk("overruns_frame0", 32'(ovr_cnt[0]),   32'd1);
        chk("overruns_frame1", 32'(ovr_cnt[1]),   32'd0);
        chk("line0_req_frame2", 32'(line0_cnt[2]), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
